// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the commit stage and its helpers.
package core_config_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Micro-code entry the PC is forced to when a halt trap is taken.
    localparam logic [XLEN-1:0] IF_TRAP_UCODE = 32'h0000_0200;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } commit_state_t;

endpackage

// File: rtl/commit_prio_picker.sv
// Picks up to NUM_WB channels from an eligible mask: aged channels first in
// PRIO_ORDER, then the remaining eligible channels in PRIO_ORDER.
module commit_prio_picker #(
    parameter int                   NUM_ALU    = 6,
    parameter int                   NUM_WB     = 2,
    // 4-bit channel index per entry, entry 0 (lowest nibble) is highest priority
    parameter logic [NUM_ALU*4-1:0] PRIO_ORDER = 24'h045321
) (
    input  logic [NUM_ALU-1:0]             eligible,
    input  logic [NUM_ALU-1:0]             aged,
    output logic [NUM_WB-1:0][NUM_ALU-1:0] grant,
    output logic [NUM_WB-1:0]              grant_vld
);

    logic [NUM_ALU-1:0] taken;
    logic               found;

    // Fill ports in order; each port takes the first untaken channel, aged pass before normal pass.
    always_comb begin
        taken     = '0;
        grant     = '0;
        grant_vld = '0;
        found     = 1'b0;
        for (int w = 0; w < NUM_WB; w++) begin
            found = 1'b0;
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < NUM_ALU; k++) begin
                    for (int c = 0; c < NUM_ALU; c++) begin
                        if (!found && (int'(PRIO_ORDER[k*4 +: 4]) == c) &&
                            eligible[c] && !taken[c] && ((pass == 1) || aged[c])) begin
                            found        = 1'b1;
                            grant[w][c]  = 1'b1;
                            grant_vld[w] = 1'b1;
                            taken[c]     = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_unit.sv
// Write-back / commit stage: grants ALU results to register-file ports,
// handles PC redirects and halt traps, and ages starving channels.
module commit_unit
    import core_config_pkg::*;
#(
    parameter int                   NUM_ALU      = 6,
    parameter int                   NUM_WB       = 2,
    parameter logic [NUM_ALU*4-1:0] PRIO_ORDER   = 24'h045321,
    parameter int                   STARVE_LIMIT = 8,
    parameter int                   FLUSH_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_ALU-1:0]                  alu_valid,
    input  logic [NUM_ALU-1:0]                  alu_error,
    input  logic [NUM_ALU-1:0]                  alu_req,
    input  logic [NUM_ALU-1:0][XLEN-1:0]        alu_res,
    input  logic [NUM_ALU-1:0][REG_ADDR_W-1:0]  alu_rd,
    output logic [NUM_ALU-1:0]                  alu_clear,
    output logic [NUM_WB-1:0][XLEN-1:0]         reg_data,
    output logic [NUM_WB-1:0][REG_ADDR_W-1:0]   reg_addr,
    output logic [NUM_WB-1:0]                   reg_we,
    output logic [XLEN-1:0]                     pc_value,
    output logic                                pc_we,
    output logic                                pc_enable,
    input  logic                                halt_needed,
    output logic                                issuer_flush,
    output logic                                commit_err,
    output logic [$clog2(NUM_ALU)-1:0]          commit_err_id
);

    localparam int ID_W  = $clog2(NUM_ALU);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    commit_state_t                  state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_ALU-1:0]             clear_q, clear_d;
    logic [NUM_ALU-1:0][AGE_W-1:0]  age_q, age_d;

    logic [NUM_ALU-1:0]             eligible;
    logic [NUM_ALU-1:0]             aged;
    logic [NUM_ALU-1:0]             req_mask;
    logic [NUM_ALU-1:0]             pick_mask;
    logic [NUM_ALU-1:0]             granted;
    logic                           any_req;
    logic [NUM_WB-1:0][NUM_ALU-1:0] pick_grant;
    logic [NUM_WB-1:0]              pick_vld;

    assign alu_clear = clear_q;

    // Channels cleared this cycle are masked so a result is never committed twice;
    // when a redirect is pending only redirect channels compete.
    always_comb begin
        eligible  = alu_valid & ~clear_q;
        req_mask  = eligible & alu_req;
        any_req   = |req_mask;
        pick_mask = any_req ? req_mask : eligible;
        for (int i = 0; i < NUM_ALU; i++) begin
            aged[i] = (age_q[i] == AGE_MAX);
        end
    end

    commit_prio_picker #(
        .NUM_ALU    (NUM_ALU),
        .NUM_WB     (NUM_WB),
        .PRIO_ORDER (PRIO_ORDER)
    ) u_picker (
        .eligible  (pick_mask),
        .aged      (aged),
        .grant     (pick_grant),
        .grant_vld (pick_vld)
    );

    // Commit outputs and next FSM state; halt in RUN wins over redirect and grants.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_d      = '0;
        granted      = '0;
        reg_data     = '0;
        reg_addr     = '0;
        reg_we       = '0;
        pc_value     = '0;
        pc_we        = 1'b0;
        pc_enable    = 1'b1;
        issuer_flush = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (halt_needed) begin
                        pc_value     = IF_TRAP_UCODE;
                        pc_we        = 1'b1;
                        issuer_flush = 1'b1;
                        pc_enable    = 1'b0;
                        clear_d      = '1;
                        state_d      = TRAP;
                        cnt_d        = CNT_INIT;
                    end else if (any_req) begin
                        for (int c = 0; c < NUM_ALU; c++) begin
                            if (pick_grant[0][c]) begin
                                pc_value = pc_value | alu_res[c];
                            end
                        end
                        pc_we        = 1'b1;
                        issuer_flush = 1'b1;
                        granted      = pick_grant[0];
                        clear_d      = granted;
                    end else begin
                        for (int w = 0; w < NUM_WB; w++) begin
                            if (pick_vld[w]) begin
                                for (int c = 0; c < NUM_ALU; c++) begin
                                    if (pick_grant[w][c]) begin
                                        reg_data[w] = reg_data[w] | alu_res[c];
                                        reg_addr[w] = reg_addr[w] | alu_rd[c];
                                    end
                                end
                                // x0 writes are discarded but the channel is still consumed
                                reg_we[w] = (reg_addr[w] != '0);
                                granted   = granted | pick_grant[w];
                            end
                        end
                        clear_d = granted;
                    end
                end
                TRAP, DRAIN: begin
                    issuer_flush = 1'b1;
                    pc_enable    = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating per-channel age: grows while eligible and passed over, resets on grant or idle.
    always_comb begin
        for (int i = 0; i < NUM_ALU; i++) begin
            if (!alu_valid[i] || granted[i]) begin
                age_d[i] = '0;
            end else if (eligible[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + 1'b1;
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    // Error summary is independent of FSM state: lowest-index erroring channel.
    always_comb begin
        commit_err    = |alu_error;
        commit_err_id = '0;
        for (int i = NUM_ALU - 1; i >= 0; i--) begin
            if (alu_error[i]) begin
                commit_err_id = ID_W'(i);
            end
        end
    end

    // State, drain counter, consume strobes and ages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            clear_q <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: table of per-cycle vectors through a scoreboard
// queue, plus hand-written reset and starvation sequences.
module tb_commit_unit;
    import core_config_pkg::*;

    localparam int NA = 6;
    localparam int NW = 2;
    localparam int SL = 8;

    logic                        clk;
    logic                        rst_n;
    logic [NA-1:0]               alu_valid, alu_error, alu_req, alu_clear;
    logic [NA-1:0][XLEN-1:0]     alu_res;
    logic [NA-1:0][REG_ADDR_W-1:0] alu_rd;
    logic [NW-1:0][XLEN-1:0]     reg_data;
    logic [NW-1:0][REG_ADDR_W-1:0] reg_addr;
    logic [NW-1:0]               reg_we;
    logic [XLEN-1:0]             pc_value;
    logic                        pc_we, pc_enable, halt_needed, issuer_flush, commit_err;
    logic [2:0]                  commit_err_id;

    int checks = 0;
    int errors = 0;

    commit_unit #(
        .NUM_ALU      (NA),
        .NUM_WB       (NW),
        .PRIO_ORDER   (24'h045321),
        .STARVE_LIMIT (SL),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_error     (alu_error),
        .alu_req       (alu_req),
        .alu_res       (alu_res),
        .alu_rd        (alu_rd),
        .alu_clear     (alu_clear),
        .reg_data      (reg_data),
        .reg_addr      (reg_addr),
        .reg_we        (reg_we),
        .pc_value      (pc_value),
        .pc_we         (pc_we),
        .pc_enable     (pc_enable),
        .halt_needed   (halt_needed),
        .issuer_flush  (issuer_flush),
        .commit_err    (commit_err),
        .commit_err_id (commit_err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rstn;
        logic        halt;
        logic [5:0]  valid;
        logic [5:0]  req;
        logic [5:0]  err;
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        pcwe;
        logic [31:0] pcv;
        logic        fl;
        logic        pcen;
        logic [5:0]  clr;
        logic        cerr;
        logic [2:0]  cid;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic rstn, input logic halt,
                                input logic [5:0] valid, input logic [5:0] req, input logic [5:0] err,
                                input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic pcwe, input logic [31:0] pcv, input logic fl, input logic pcen,
                                input logic [5:0] clr, input logic cerr, input logic [2:0] cid);
        vec_t v;
        v.rstn = rstn; v.halt = halt; v.valid = valid; v.req = req; v.err = err;
        v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.pcwe = pcwe; v.pcv = pcv; v.fl = fl; v.pcen = pcen;
        v.clr = clr; v.cerr = cerr; v.cid = cid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        vec_t v;
        logic        found;
        int          fcyc;
        logic [31:0] fdata;

        // fixed per-channel destination registers and results
        alu_rd  = '0;
        alu_res = '0;
        alu_rd[0] = 5'd5;  alu_res[0] = 32'h100;
        alu_rd[1] = 5'd9;  alu_res[1] = 32'h80;
        alu_rd[2] = 5'd6;  alu_res[2] = 32'h300;
        alu_rd[3] = 5'd10; alu_res[3] = 32'h400;
        alu_rd[4] = 5'd7;  alu_res[4] = 32'h500;
        alu_rd[5] = 5'd0;  alu_res[5] = 32'h600;

        //                rst halt valid      req        err        we     a0     d0        a1    d1     pcwe pcv           fl    pcen  clr        cerr cid
        // two-port grant in priority order, then the lower-priority channel
        vecs.push_back(mk(1, 0, 6'b010101, 6'b000000, 6'b000000, 2'b11, 5'd6,  32'h300, 5'd7, 32'h500, 0, 32'h0,        0, 1, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b010101, 6'b000000, 6'b000000, 2'b01, 5'd5,  32'h100, 5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b010100, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b000000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b000001, 0, 3'd0));
        // redirect defers the plain write to the next cycle
        vecs.push_back(mk(1, 0, 6'b000110, 6'b000010, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   1, 32'h80,       1, 1, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b000110, 6'b000010, 6'b000000, 2'b01, 5'd6,  32'h300, 5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b000010, 0, 3'd0));
        // x0 destination: port used without write enable; error id is lowest erroring channel
        vecs.push_back(mk(1, 0, 6'b100000, 6'b000000, 6'b001000, 2'b00, 5'd0,  32'h600, 5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b000100, 1, 3'd3));
        vecs.push_back(mk(1, 0, 6'b000000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b100000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b000000, 6'b000000, 6'b110000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b000000, 1, 3'd4));
        // halt trap: trap PC same cycle, clear-all next, flush for 3 cycles, halt ignored while draining
        vecs.push_back(mk(1, 1, 6'b001000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   1, IF_TRAP_UCODE, 1, 0, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b001000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        1, 0, 6'b111111, 0, 3'd0));
        vecs.push_back(mk(1, 1, 6'b001000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        1, 0, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b001000, 6'b000000, 6'b000000, 2'b01, 5'd10, 32'h400, 5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b000000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b001000, 0, 3'd0));
        // reset right after a trap drops the FSM and the pending clear
        vecs.push_back(mk(1, 1, 6'b000000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   1, IF_TRAP_UCODE, 1, 0, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(0, 0, 6'b000000, 6'b000000, 6'b000110, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b111111, 1, 3'd1));
        vecs.push_back(mk(1, 0, 6'b010000, 6'b000000, 6'b000000, 2'b01, 5'd7,  32'h500, 5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b000000, 0, 3'd0));
        vecs.push_back(mk(1, 0, 6'b000000, 6'b000000, 6'b000000, 2'b00, 5'd0,  32'h0,   5'd0, 32'h0,   0, 32'h0,        0, 1, 6'b010000, 0, 3'd0));

        // reset held two cycles with every channel valid
        rst_n       = 1'b0;
        halt_needed = 1'b0;
        alu_valid   = '1;
        alu_req     = '0;
        alu_error   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reg_we",    32'(reg_we),    32'h0);
        chk("rst_alu_clear", 32'(alu_clear), 32'h0);
        chk("rst_pc_we",     32'(pc_we),     32'h0);
        chk("rst_flush",     32'(issuer_flush), 32'h0);
        chk("rst_pc_enable", 32'(pc_enable), 32'h1);

        // table-driven vectors, one per cycle, expectations queued as stimulus is applied
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            v           = vecs[i];
            rst_n       = v.rstn;
            halt_needed = v.halt;
            alu_valid   = v.valid;
            alu_req     = v.req;
            alu_error   = v.err;
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_reg_we", i),    32'(reg_we),        32'(e.we));
            chk($sformatf("v%0d_addr0", i),     32'(reg_addr[0]),   32'(e.a0));
            chk($sformatf("v%0d_data0", i),     reg_data[0],        e.d0);
            chk($sformatf("v%0d_addr1", i),     32'(reg_addr[1]),   32'(e.a1));
            chk($sformatf("v%0d_data1", i),     reg_data[1],        e.d1);
            chk($sformatf("v%0d_pc_we", i),     32'(pc_we),         32'(e.pcwe));
            chk($sformatf("v%0d_pc_value", i),  pc_value,           e.pcv);
            chk($sformatf("v%0d_flush", i),     32'(issuer_flush),  32'(e.fl));
            chk($sformatf("v%0d_pc_enable", i), 32'(pc_enable),     32'(e.pcen));
            chk($sformatf("v%0d_alu_clear", i), 32'(alu_clear),     32'(e.clr));
            chk($sformatf("v%0d_commit_err", i), 32'(commit_err),   32'(e.cerr));
            chk($sformatf("v%0d_err_id", i),    32'(commit_err_id), 32'(e.cid));
        end

        // starvation: all channels valid; ch0 is lowest priority and must be forced in by aging
        found = 1'b0;
        fcyc  = -1;
        fdata = '0;
        for (int c = 0; c <= SL && !found; c++) begin
            @(posedge clk);
            #1;
            rst_n       = 1'b1;
            halt_needed = 1'b0;
            alu_valid   = '1;
            alu_req     = '0;
            alu_error   = '0;
            @(negedge clk);
            if (c == 0) begin
                chk("starve_c0_addr0", 32'(reg_addr[0]), 32'd9);
                chk("starve_c0_addr1", 32'(reg_addr[1]), 32'd6);
            end
            for (int p = 0; p < NW; p++) begin
                if (reg_we[p] && (reg_addr[p] == 5'd5)) begin
                    found = 1'b1;
                    fcyc  = c;
                    fdata = reg_data[p];
                end
            end
        end
        chk("starve_ch0_granted", 32'(found), 32'h1);
        chk("starve_ch0_data",    fdata,      32'h100);
        if (found) begin
            chk("starve_ch0_in_time", 32'(fcyc <= SL), 32'h1);
        end

        @(posedge clk);
        #1;
        alu_valid = '0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
